// File: rtl/sram_access_target.sv
// rtl/sram_access_target.sv - SRAM target for sram_access_req/resp with fixed-latency responses
// Drives a byte-enabled 64-bit synchronous SRAM and returns one response per accepted request.
module sram_access_target #(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sram_access_req__valid,
   input  logic [3:0]            sram_access_req__id,
   input  logic                  sram_access_req__read_not_write,
   input  logic [7:0]            sram_access_req__byte_enable,
   input  logic [31:0]           sram_access_req__address,
   input  logic [63:0]           sram_access_req__write_data,
   input  logic                  sram_hold,
   output logic                  sram_access_resp__ack,
   output logic                  sram_access_resp__valid,
   output logic [3:0]            sram_access_resp__id,
   output logic [63:0]           sram_access_resp__data,
   output logic                  sram_select,
   output logic                  sram_read_not_write,
   output logic [ADDR_WIDTH-1:0] sram_address,
   output logic [7:0]            sram_byte_enable,
   output logic [63:0]           sram_write_data,
   input  logic [63:0]           sram_read_data,
   output logic [7:0]            range_error_count
);

   localparam int DEPTH = READ_LATENCY + 1;

   logic accept;
   logic in_range;

   logic [DEPTH-1:0]      pipe_valid;
   logic [DEPTH-1:0]      pipe_read;
   logic [DEPTH-1:0]      pipe_in_range;
   logic [DEPTH-1:0][3:0] pipe_id;

   assign sram_access_resp__ack = sram_access_req__valid & ~sram_hold;
   assign accept                = sram_access_resp__ack;
   assign in_range              = ((sram_access_req__address >> ADDR_WIDTH) == 32'd0);

   // Out-of-range requests never reach the SRAM, but still occupy a response slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sram_select         <= 1'b0;
         sram_read_not_write <= 1'b0;
         sram_address        <= '0;
         sram_byte_enable    <= 8'h00;
         sram_write_data     <= 64'h0;
         range_error_count   <= 8'h00;
      end else begin
         sram_select <= accept & in_range;
         if (accept && in_range) begin
            sram_read_not_write <= sram_access_req__read_not_write;
            sram_address        <= sram_access_req__address[ADDR_WIDTH-1:0];
            sram_byte_enable    <= sram_access_req__byte_enable;
            sram_write_data     <= sram_access_req__write_data;
         end
         if (accept && !in_range && range_error_count != 8'hFF) begin
            range_error_count <= range_error_count + 8'd1;
         end
      end
   end

   // Stage 0 lines up with sram_select; the last stage lines up with valid read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_valid    <= '0;
         pipe_read     <= '0;
         pipe_in_range <= '0;
         pipe_id       <= '0;
      end else begin
         pipe_valid[0]    <= accept;
         pipe_read[0]     <= sram_access_req__read_not_write;
         pipe_in_range[0] <= in_range;
         pipe_id[0]       <= sram_access_req__id;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_valid[i]    <= pipe_valid[i-1];
            pipe_read[i]     <= pipe_read[i-1];
            pipe_in_range[i] <= pipe_in_range[i-1];
            pipe_id[i]       <= pipe_id[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sram_access_resp__valid <= 1'b0;
         sram_access_resp__id    <= 4'h0;
         sram_access_resp__data  <= 64'h0;
      end else begin
         sram_access_resp__valid <= pipe_valid[READ_LATENCY];
         if (pipe_valid[READ_LATENCY]) begin
            sram_access_resp__id   <= pipe_id[READ_LATENCY];
            sram_access_resp__data <= (pipe_read[READ_LATENCY] && pipe_in_range[READ_LATENCY])
                                      ? sram_read_data : 64'h0;
         end
      end
   end

endmodule

// File: tb/tb_sram_access_target.sv
// tb/tb_sram_access_target.sv - directed bench for sram_access_target
// Two instances: READ_LATENCY=1 (a_*) and READ_LATENCY=3 (b_*), each with a behavioural SRAM.
module tb_sram_access_target;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        a_valid, a_rnw, a_hold;
   logic [3:0]  a_id;
   logic [7:0]  a_be;
   logic [31:0] a_addr;
   logic [63:0] a_wdata;
   logic        a_ack, a_rvalid, a_sel, a_srnw;
   logic [3:0]  a_rid;
   logic [63:0] a_rdata, a_swdata, a_srdata;
   logic [9:0]  a_saddr;
   logic [7:0]  a_sbe, a_cnt;

   logic        b_valid, b_rnw, b_hold;
   logic [3:0]  b_id;
   logic [7:0]  b_be;
   logic [31:0] b_addr;
   logic [63:0] b_wdata;
   logic        b_ack, b_rvalid, b_sel, b_srnw;
   logic [3:0]  b_rid;
   logic [63:0] b_rdata, b_swdata, b_srdata;
   logic [9:0]  b_saddr;
   logic [7:0]  b_sbe, b_cnt;

   sram_access_target #(.ADDR_WIDTH(10), .READ_LATENCY(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n),
      .sram_access_req__valid(a_valid), .sram_access_req__id(a_id),
      .sram_access_req__read_not_write(a_rnw), .sram_access_req__byte_enable(a_be),
      .sram_access_req__address(a_addr), .sram_access_req__write_data(a_wdata),
      .sram_hold(a_hold), .sram_access_resp__ack(a_ack),
      .sram_access_resp__valid(a_rvalid), .sram_access_resp__id(a_rid),
      .sram_access_resp__data(a_rdata), .sram_select(a_sel),
      .sram_read_not_write(a_srnw), .sram_address(a_saddr),
      .sram_byte_enable(a_sbe), .sram_write_data(a_swdata),
      .sram_read_data(a_srdata), .range_error_count(a_cnt)
   );

   sram_access_target #(.ADDR_WIDTH(10), .READ_LATENCY(3)) u_dut_b (
      .clk(clk), .reset_n(reset_n),
      .sram_access_req__valid(b_valid), .sram_access_req__id(b_id),
      .sram_access_req__read_not_write(b_rnw), .sram_access_req__byte_enable(b_be),
      .sram_access_req__address(b_addr), .sram_access_req__write_data(b_wdata),
      .sram_hold(b_hold), .sram_access_resp__ack(b_ack),
      .sram_access_resp__valid(b_rvalid), .sram_access_resp__id(b_rid),
      .sram_access_resp__data(b_rdata), .sram_select(b_sel),
      .sram_read_not_write(b_srnw), .sram_address(b_saddr),
      .sram_byte_enable(b_sbe), .sram_write_data(b_swdata),
      .sram_read_data(b_srdata), .range_error_count(b_cnt)
   );

   // Behavioural SRAMs: data appears READ_LATENCY cycles after the sampling edge.
   logic [63:0] a_mem [0:1023];
   logic [63:0] a_rd_q = 64'h0;
   logic [63:0] b_mem [0:1023];
   logic [63:0] b_rd_q [0:2];
   assign a_srdata = a_rd_q;
   assign b_srdata = b_rd_q[2];

   always @(posedge clk) begin
      if (a_sel) begin
         if (a_srnw) a_rd_q <= a_mem[a_saddr];
         else for (int k = 0; k < 8; k++) if (a_sbe[k]) a_mem[a_saddr][8*k +: 8] <= a_swdata[8*k +: 8];
      end
   end

   always @(posedge clk) begin
      if (b_sel) begin
         if (b_srnw) b_rd_q[0] <= b_mem[b_saddr];
         else for (int k = 0; k < 8; k++) if (b_sbe[k]) b_mem[b_saddr][8*k +: 8] <= b_swdata[8*k +: 8];
      end
      b_rd_q[1] <= b_rd_q[0];
      b_rd_q[2] <= b_rd_q[1];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single cycle; returns in cycle 1 after the accept.
   task automatic send_a(input logic [3:0] id, input logic rnw, input logic [7:0] be,
                         input logic [31:0] addr, input logic [63:0] wd);
      a_valid = 1'b1; a_id = id; a_rnw = rnw; a_be = be; a_addr = addr; a_wdata = wd;
      tick();
      a_valid = 1'b0;
   endtask

   task automatic send_b(input logic [3:0] id, input logic rnw, input logic [7:0] be,
                         input logic [31:0] addr, input logic [63:0] wd);
      b_valid = 1'b1; b_id = id; b_rnw = rnw; b_be = be; b_addr = addr; b_wdata = wd;
      tick();
      b_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      a_valid = 0; a_rnw = 0; a_hold = 0; a_id = 0; a_be = 0; a_addr = 0; a_wdata = 0;
      b_valid = 0; b_rnw = 0; b_hold = 0; b_id = 0; b_be = 0; b_addr = 0; b_wdata = 0;
      tick(); tick();
      checks++;
      if ({a_rvalid, a_rid, a_rdata, a_sel, a_srnw, a_saddr, a_sbe, a_swdata, a_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_a: got rv=%b id=%h d=%h sel=%b rnw=%b ad=%h be=%h wd=%h cnt=%h required all 0",
                  a_rvalid, a_rid, a_rdata, a_sel, a_srnw, a_saddr, a_sbe, a_swdata, a_cnt);
      end
      checks++;
      if ({b_rvalid, b_rid, b_rdata, b_sel, b_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_b: got rv=%b id=%h d=%h sel=%b cnt=%h required all 0",
                  b_rvalid, b_rid, b_rdata, b_sel, b_cnt);
      end
      checks++;
      if (a_ack !== 1'b0) begin errors++; $display("FAIL ack_idle: got %b required 0", a_ack); end
      a_valid = 1'b1; a_hold = 1'b1; #1;
      checks++;
      if (a_ack !== 1'b0) begin errors++; $display("FAIL ack_held: got %b required 0", a_ack); end
      a_hold = 1'b0; #1;
      checks++;
      if (a_ack !== 1'b1) begin errors++; $display("FAIL ack_comb: got %b required 1", a_ack); end
      a_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_read();
      a_valid = 1'b1; a_id = 4'd3; a_rnw = 1'b0; a_be = 8'hFF; a_addr = 32'd5; a_wdata = 64'h1122334455667788;
      #1;
      checks++;
      if (a_ack !== 1'b1) begin errors++; $display("FAIL write_ack: got %b required 1", a_ack); end
      tick();
      a_valid = 1'b0;
      checks++;
      if ({a_sel, a_srnw, a_saddr, a_sbe, a_swdata} !== {1'b1, 1'b0, 10'd5, 8'hFF, 64'h1122334455667788}) begin
         errors++;
         $display("FAIL write_sram: got sel=%b rnw=%b ad=%h be=%h wd=%h required 1 0 005 ff 1122334455667788",
                  a_sel, a_srnw, a_saddr, a_sbe, a_swdata);
      end
      tick();
      checks++;
      if (a_rvalid !== 1'b0) begin errors++; $display("FAIL write_early: got rv=%b required 0 in cycle 2", a_rvalid); end
      tick();
      checks++;
      if ({a_rvalid, a_rid, a_rdata} !== {1'b1, 4'd3, 64'h0}) begin
         errors++;
         $display("FAIL write_resp: got rv=%b id=%h d=%h required 1 3 0", a_rvalid, a_rid, a_rdata);
      end
      tick();
      checks++;
      if (a_rvalid !== 1'b0) begin errors++; $display("FAIL write_pulse: got rv=%b required 0", a_rvalid); end

      send_a(4'd7, 1'b1, 8'h00, 32'd5, 64'h0);
      checks++;
      if ({a_sel, a_srnw, a_saddr} !== {1'b1, 1'b1, 10'd5}) begin
         errors++;
         $display("FAIL read_sram: got sel=%b rnw=%b ad=%h required 1 1 005", a_sel, a_srnw, a_saddr);
      end
      tick(); tick();
      checks++;
      if ({a_rvalid, a_rid, a_rdata} !== {1'b1, 4'd7, 64'h1122334455667788}) begin
         errors++;
         $display("FAIL read_resp: got rv=%b id=%h d=%h required 1 7 1122334455667788", a_rvalid, a_rid, a_rdata);
      end
      tick();
   endtask

   task automatic test_byte_merge();
      send_a(4'd1, 1'b0, 8'hFF, 32'd2, 64'h0);
      tick(); tick(); tick();
      send_a(4'd2, 1'b0, 8'h0F, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF);
      tick(); tick(); tick();
      send_a(4'd4, 1'b0, 8'h00, 32'd2, 64'hDEAD_BEEF_DEAD_BEEF);
      checks++;
      if ({a_sel, a_sbe} !== {1'b1, 8'h00}) begin
         errors++; $display("FAIL be0_select: got sel=%b be=%h required 1 00", a_sel, a_sbe);
      end
      tick(); tick();
      checks++;
      if ({a_rvalid, a_rid, a_rdata} !== {1'b1, 4'd4, 64'h0}) begin
         errors++; $display("FAIL be0_resp: got rv=%b id=%h d=%h required 1 4 0", a_rvalid, a_rid, a_rdata);
      end
      tick();
      send_a(4'd5, 1'b1, 8'h00, 32'd2, 64'h0);
      tick(); tick();
      checks++;
      if ({a_rvalid, a_rid, a_rdata} !== {1'b1, 4'd5, 64'h00000000FFFFFFFF}) begin
         errors++;
         $display("FAIL merge_read: got rv=%b id=%h d=%h required 1 5 00000000ffffffff", a_rvalid, a_rid, a_rdata);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [63:0] pat [0:3];
      pat[0] = 64'hA0A0_0000_0000_0001; pat[1] = 64'hB1B1_0000_0000_0002;
      pat[2] = 64'hC2C2_0000_0000_0003; pat[3] = 64'hD3D3_0000_0000_0004;
      for (int i = 0; i < 4; i++) begin
         send_b(4'd8, 1'b0, 8'hFF, 32'd10 + 32'(i), pat[i]);
      end
      repeat (6) tick();
      for (int i = 0; i < 4; i++) begin
         b_valid = 1'b1; b_id = 4'(i); b_rnw = 1'b1; b_be = 8'h00; b_addr = 32'd10 + 32'(i);
         #1;
         checks++;
         if (b_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d: got %b required 1", i, b_ack); end
         tick();
      end
      b_valid = 1'b0;
      checks++;
      if (b_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_early: got rv=%b required 0 in cycle 4", b_rvalid); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({b_rvalid, b_rid, b_rdata} !== {1'b1, 4'(i), pat[i]}) begin
            errors++;
            $display("FAIL b2b_resp%0d: got rv=%b id=%h d=%h required 1 %h %h", i, b_rvalid, b_rid, b_rdata, 4'(i), pat[i]);
         end
      end
      tick();
      checks++;
      if (b_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got rv=%b required 0", b_rvalid); end
   endtask

   task automatic test_out_of_range();
      logic sel_seen;
      int   resp_cnt;
      send_a(4'd6, 1'b1, 8'h00, 32'h400, 64'h0);
      checks++;
      if ({a_sel, a_cnt} !== {1'b0, 8'd1}) begin
         errors++; $display("FAIL oor_first: got sel=%b cnt=%h required 0 01", a_sel, a_cnt);
      end
      tick(); tick();
      checks++;
      if ({a_rvalid, a_rid, a_rdata} !== {1'b1, 4'd6, 64'h0}) begin
         errors++; $display("FAIL oor_resp: got rv=%b id=%h d=%h required 1 6 0", a_rvalid, a_rid, a_rdata);
      end
      tick();
      sel_seen = 1'b0; resp_cnt = 0;
      a_valid = 1'b1; a_addr = 32'h400; a_rnw = 1'b1;
      repeat (299) begin
         tick();
         if (a_sel) sel_seen = 1'b1;
         if (a_rvalid) resp_cnt++;
      end
      a_valid = 1'b0;
      repeat (4) begin
         tick();
         if (a_sel) sel_seen = 1'b1;
         if (a_rvalid) resp_cnt++;
      end
      checks++;
      if (a_cnt !== 8'hFF) begin errors++; $display("FAIL oor_saturate: got %h required ff", a_cnt); end
      checks++;
      if (sel_seen !== 1'b0) begin errors++; $display("FAIL oor_select: got sel seen=%b required 0", sel_seen); end
      checks++;
      if (resp_cnt != 299) begin errors++; $display("FAIL oor_resp_count: got %0d required 299", resp_cnt); end
   endtask

   task automatic test_hold();
      logic busy;
      busy = 1'b0;
      a_valid = 1'b1; a_hold = 1'b1; a_id = 4'd9; a_rnw = 1'b1; a_addr = 32'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (a_ack !== 1'b0) begin errors++; $display("FAIL hold_ack%0d: got %b required 0", i, a_ack); end
         tick();
         if (a_sel || a_rvalid) busy = 1'b1;
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL hold_access: got activity=%b required 0", busy); end
      a_hold = 1'b0;
      #1;
      checks++;
      if (a_ack !== 1'b1) begin errors++; $display("FAIL hold_release_ack: got %b required 1", a_ack); end
      tick();
      a_valid = 1'b0;
      tick(); tick();
      checks++;
      if ({a_rvalid, a_rid, a_rdata} !== {1'b1, 4'd9, 64'h00000000FFFFFFFF}) begin
         errors++;
         $display("FAIL hold_resp: got rv=%b id=%h d=%h required 1 9 00000000ffffffff", a_rvalid, a_rid, a_rdata);
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      logic seen;
      seen = 1'b0;
      send_a(4'd11, 1'b1, 8'h00, 32'd2, 64'h0);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({a_rvalid, a_rid, a_rdata, a_sel, a_srnw, a_saddr, a_sbe, a_swdata, a_cnt} !== '0) begin
         errors++;
         $display("FAIL midflight_reset: got rv=%b id=%h d=%h sel=%b rnw=%b ad=%h be=%h wd=%h cnt=%h required all 0",
                  a_rvalid, a_rid, a_rdata, a_sel, a_srnw, a_saddr, a_sbe, a_swdata, a_cnt);
      end
      tick(); tick();
      reset_n = 1'b1;
      repeat (8) begin
         tick();
         if (a_rvalid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midflight_ghost: got response=%b required 0", seen); end
      send_a(4'd12, 1'b1, 8'h00, 32'd2, 64'h0);
      tick(); tick();
      checks++;
      if ({a_rvalid, a_rid, a_rdata} !== {1'b1, 4'd12, 64'h00000000FFFFFFFF}) begin
         errors++;
         $display("FAIL post_reset_resp: got rv=%b id=%h d=%h required 1 c 00000000ffffffff", a_rvalid, a_rid, a_rdata);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_read();
      test_byte_merge();
      test_back_to_back();
      test_out_of_range();
      test_hold();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
